// File: rtl/ndn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ndn_pkg
// Description : Shared NDN pipeline types and helpers (PIT / FIB).
// Revision    : 1.0 - initial release
// ============================================================================
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } pit_state_t;

    // Low 'len' bits set; len = 0 gives an all-zero mask.
    function automatic logic [PREFIX_W-1:0] prefix_mask(input logic [LEN_W-1:0] len);
        logic [PREFIX_W-1:0] m;
        m = '0;
        for (int i = 0; i < PREFIX_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pit_match.sv
`default_nettype none
// ============================================================================
// Module      : pit_match
// Description : Parallel prefix compare over all PIT entries with lowest-index
//               priority encoders for the hit entry and the first free slot.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_match #(
    parameter int DEPTH    = 8,
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W    = ndn_pkg::LEN_W
) (
    input  logic [DEPTH-1:0]          i_valid,
    input  logic [DEPTH*PREFIX_W-1:0] i_entry_prefix,
    input  logic [DEPTH*LEN_W-1:0]    i_entry_len,
    input  logic [PREFIX_W-1:0]       i_key_prefix,
    input  logic [LEN_W-1:0]          i_key_len,
    output logic                      o_hit,
    output logic [$clog2(DEPTH)-1:0]  o_hit_idx,
    output logic                      o_free,
    output logic [$clog2(DEPTH)-1:0]  o_free_idx
);
    import ndn_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]    w_match;
    logic [PREFIX_W-1:0] w_key_mask;

    // Lengths must be equal, so the key's mask covers both sides.
    assign w_key_mask = prefix_mask(i_key_len);

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_match[g] = i_valid[g]
                         && (i_entry_len[g*LEN_W +: LEN_W] == i_key_len)
                         && (((i_entry_prefix[g*PREFIX_W +: PREFIX_W] ^ i_key_prefix)
                              & w_key_mask) == '0);
    end

    always_comb begin
        o_hit      = 1'b0;
        o_hit_idx  = '0;
        o_free     = 1'b0;
        o_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit     = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
            if (!i_valid[i]) begin
                o_free     = 1'b1;
                o_free_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pit_table.sv
`default_nettype none
// ============================================================================
// Module      : pit_table
// Description : Pending Interest Table - duplicate suppression, FIB forwarding,
//               data-return lookup and entry aging.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_table #(
    parameter int DEPTH    = 8,
    parameter int LIFETIME = 1024,
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W    = ndn_pkg::LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   interest_valid,
    input  logic [PREFIX_W-1:0]    interest_prefix,
    input  logic [LEN_W-1:0]       interest_len,
    output logic                   interest_ready,
    output logic [PREFIX_W-1:0]    pit_in_prefix,
    output logic [LEN_W-1:0]       pit_in_len,
    output logic                   fib_out_bit,
    input  logic [PREFIX_W-1:0]    pit_out_prefix,
    input  logic [LEN_W-1:0]       pit_out_len,
    input  logic                   prefix_ready,
    output logic                   start_send_to_pit,
    output logic                   rejected,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   interest_dropped,
    output logic                   entry_expired
);
    import ndn_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(LIFETIME + 1);
    localparam logic [TMR_W-1:0] C_LIFETIME = TMR_W'(LIFETIME);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(1);

    pit_state_t r_state;
    pit_state_t w_state_nxt;

    logic [DEPTH-1:0]    r_valid;
    logic [PREFIX_W-1:0] r_prefix [DEPTH];
    logic [LEN_W-1:0]    r_len    [DEPTH];
    logic [TMR_W-1:0]    r_timer  [DEPTH];

    logic                r_live;
    logic [PREFIX_W-1:0] r_pit_in_prefix;
    logic [LEN_W-1:0]    r_pit_in_len;
    logic                r_resp_hit;
    logic                r_dropped;
    logic                r_expired;

    logic [DEPTH*PREFIX_W-1:0] w_flat_prefix;
    logic [DEPTH*LEN_W-1:0]    w_flat_len;

    logic             w_int_hit, w_int_free, w_qry_hit, w_qry_free, w_free;
    logic [IDX_W-1:0] w_int_hit_idx, w_int_free_idx, w_qry_hit_idx, w_qry_free_idx, w_free_idx;

    logic w_accept, w_do_query, w_do_insert, w_do_refresh, w_do_drop;
    logic [DEPTH-1:0] w_consume, w_insert, w_refresh, w_expire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_flat_prefix[g*PREFIX_W +: PREFIX_W] = r_prefix[g];
        assign w_flat_len[g*LEN_W +: LEN_W]          = r_len[g];
    end

    pit_match #(.DEPTH(DEPTH), .PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) u_match_int (
        .i_valid        (r_valid),
        .i_entry_prefix (w_flat_prefix),
        .i_entry_len    (w_flat_len),
        .i_key_prefix   (interest_prefix),
        .i_key_len      (interest_len),
        .o_hit          (w_int_hit),
        .o_hit_idx      (w_int_hit_idx),
        .o_free         (w_int_free),
        .o_free_idx     (w_int_free_idx)
    );

    pit_match #(.DEPTH(DEPTH), .PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) u_match_qry (
        .i_valid        (r_valid),
        .i_entry_prefix (w_flat_prefix),
        .i_entry_len    (w_flat_len),
        .i_key_prefix   (pit_out_prefix),
        .i_key_len      (pit_out_len),
        .o_hit          (w_qry_hit),
        .o_hit_idx      (w_qry_hit_idx),
        .o_free         (w_qry_free),
        .o_free_idx     (w_qry_free_idx)
    );

    // Both instances see the same valid vector, so their free outputs are identical.
    assign w_free     = w_int_free & w_qry_free;
    assign w_free_idx = w_int_free_idx & w_qry_free_idx;

    assign interest_ready = r_live && (r_state == ST_IDLE) && !prefix_ready;
    assign w_accept       = interest_valid && interest_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_do_query   = 1'b0;
        w_do_insert  = 1'b0;
        w_do_refresh = 1'b0;
        w_do_drop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (prefix_ready) begin
                    w_do_query  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_accept) begin
                    if (w_int_hit) begin
                        w_do_refresh = 1'b1;
                    end else if (w_free) begin
                        w_do_insert = 1'b1;
                        w_state_nxt = ST_FWD;
                    end else begin
                        w_do_drop = 1'b1;
                    end
                end
            end
            ST_FWD:  w_state_nxt = ST_IDLE;
            ST_RESP: if (!prefix_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Consume/refresh on the expiry cycle keep that entry from counting as expired.
    always_comb begin
        w_consume = '0;
        w_insert  = '0;
        w_refresh = '0;
        w_expire  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_consume[i] = w_do_query && w_qry_hit && (w_qry_hit_idx == IDX_W'(i));
            w_insert[i]  = w_do_insert && (w_free_idx == IDX_W'(i));
            w_refresh[i] = w_do_refresh && (w_int_hit_idx == IDX_W'(i));
            w_expire[i]  = r_valid[i] && (r_timer[i] == C_TMR_LAST)
                        && !w_consume[i] && !w_refresh[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_prefix[i] <= '0;
                r_len[i]    <= '0;
                r_timer[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_consume[i] || w_expire[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_insert[i] || w_refresh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_timer[i] <= C_LIFETIME;
                end else if (r_valid[i]) begin
                    r_timer[i] <= r_timer[i] - TMR_W'(1);
                end
                if (w_insert[i]) begin
                    r_prefix[i] <= interest_prefix;
                    r_len[i]    <= interest_len;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live          <= 1'b0;
            r_pit_in_prefix <= '0;
            r_pit_in_len    <= '0;
            r_resp_hit      <= 1'b0;
            r_dropped       <= 1'b0;
            r_expired       <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_dropped <= w_do_drop;
            r_expired <= |w_expire;
            if (w_do_insert) begin
                r_pit_in_prefix <= interest_prefix;
                r_pit_in_len    <= interest_len;
            end else if (r_state == ST_FWD) begin
                r_pit_in_prefix <= '0;
                r_pit_in_len    <= '0;
            end
            if (w_do_query) begin
                r_resp_hit <= w_qry_hit;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(r_valid[i]);
        end
    end

    assign fib_out_bit       = (r_state == ST_FWD);
    assign pit_in_prefix     = r_pit_in_prefix;
    assign pit_in_len        = r_pit_in_len;
    assign start_send_to_pit = (r_state == ST_RESP) && r_resp_hit;
    assign rejected          = (r_state == ST_RESP) && !r_resp_hit;
    assign interest_dropped  = r_dropped;
    assign entry_expired     = r_expired;

endmodule
`default_nettype wire

// File: doc/pit_table.md
Name: pit_table

Overview:
- Pending Interest Table stage directly upstream of the FIB.
- Records outgoing interests, suppresses duplicates, forwards new interests to the FIB (pit_in_prefix/pit_in_len/fib_out_bit).
- Answers FIB data-return queries (pit_out_prefix/pit_out_len/prefix_ready) with start_send_to_pit (pending entry hit) or rejected (no entry).
- Entries age out after a fixed lifetime.

Parameters:
DEPTH, 8, number of table entries (power of 2, 2..16)
LIFETIME, 1024, cycles an entry stays valid without refresh (>=2)
PREFIX_W, 64, prefix width in bits
LEN_W, 6, prefix length field width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
interest_valid  in  1  upstream interest offered
interest_prefix  in  PREFIX_W  interest name prefix, right-aligned
interest_len  in  LEN_W  significant prefix bits
interest_ready  out  1  PIT accepts interest this cycle
pit_in_prefix  out  PREFIX_W  prefix forwarded to FIB
pit_in_len  out  LEN_W  length forwarded to FIB
fib_out_bit  out  1  one-cycle strobe: pit_in_* valid
pit_out_prefix  in  PREFIX_W  prefix of data returned by FIB
pit_out_len  in  LEN_W  length of returned data prefix
prefix_ready  in  1  FIB query valid, level, held until answered
start_send_to_pit  out  1  query hit, entry consumed
rejected  out  1  query miss
occupancy  out  $clog2(DEPTH)+1  valid entry count
interest_dropped  out  1  one-cycle pulse: table full, interest discarded
entry_expired  out  1  one-cycle pulse: at least one entry aged out

Behaviour:
- Reset: all entries invalid. Outputs 0 except interest_ready. FSM in IDLE. interest_ready=1 one cycle after rst deasserts.
- Match rule: entry matches when len equal and (prefix & mask)==(entry & mask), mask=(1<<len)-1. len=0 matches only len=0 entries.
- Lookup: single-cycle parallel compare over all valid entries. Lowest-index match wins; free slot = lowest invalid index.
- FSM states: IDLE, FWD, RESP.
- IDLE, prefix_ready=1 (priority over interests; interest_ready=0 that cycle):
  - hit: invalidate entry, go RESP with start_send_to_pit=1.
  - miss: go RESP with rejected=1.
- IDLE, interest_valid & interest_ready:
  - hit: aggregate; reload entry timer to LIFETIME; stay IDLE; no FIB traffic.
  - miss & free slot: write entry with timer=LIFETIME; register pit_in_*; go FWD.
  - miss & full: interest_dropped=1 one cycle; stay IDLE.
- FWD: fib_out_bit=1 for exactly 1 cycle with pit_in_* stable. Next cycle pit_in_* cleared to 0, back to IDLE. interest_ready=0 in FWD.
- RESP: start_send_to_pit/rejected held while prefix_ready=1; minimum 1 cycle. Cleared and return to IDLE on first cycle prefix_ready=0.
- Latency: interest accept -> fib_out_bit next cycle. prefix_ready rise -> response next cycle.
- Aging:
  - Each valid entry's timer decrements every cycle in all states.
  - On reaching 1, entry invalidates next cycle; entry_expired pulses once, even if several entries expire together.
  - Refresh or consume in the same cycle as expiry wins; no expire pulse for that entry.
- Occupancy: updated the cycle after insert/consume/expire. Simultaneous insert+expire nets correctly; never exceeds DEPTH.
- rst asserted mid-operation: immediate clear; no partial strobe completes.

Decomposition:
- Package ndn_pkg: PREFIX_W, LEN_W, FSM state enum, prefix-mask function. Shared with fib.
- Sub-module pit_match: combinational DEPTH-way compare plus priority encoders. Outputs hit, hit_idx, free, free_idx.
- Instantiated twice: interest path and data-query path.

Test Plan:
1. Reset then interest 64'h0000FFFF0000FFFF/len 10 -> interest_ready=1; next cycle fib_out_bit=1 with pit_in_prefix=64'h...FFFF, pit_in_len=10; occupancy=1.
2. Same interest again within LIFETIME -> no fib_out_bit, occupancy stays 1, timer reloaded (entry survives LIFETIME cycles after second interest).
3. prefix_ready with 64'h0000FFFF0000FFFF/len 10 held 5 cycles -> start_send_to_pit=1 from cycle+1 until prefix_ready drops; occupancy=0. Repeat query -> rejected=1, start_send_to_pit=0.
4. Fill DEPTH=8 distinct prefixes 1..8, len 8 -> 8 fib_out_bit strobes. 9th (prefix 9) -> interest_dropped pulse, no strobe.
5. Insert one entry, idle LIFETIME cycles -> entry_expired single pulse, occupancy=0. Subsequent query -> rejected.
6. interest_valid and prefix_ready asserted same cycle -> query answered first, interest_ready=0. Interest accepted on first IDLE cycle after prefix_ready falls. Async rst low mid-FWD -> fib_out_bit=0 immediately, occupancy=0.
